regfile_wb_queue: RTL and testbench

- Write-side initiator for the 32x32 two-read/one-write register file.
- Accepts completed results from two pipeline sources: A (ALU) and B (memory).
- Buffers results in an in-order queue and drains at most one per cycle into the register file write port.
- Provides combinational forwarding lookups so readers see queued, not-yet-written values.

---
 rtl/mips_pkg.sv | 18 +
 rtl/wbq_fwd_lookup.sv | 39 +++
 rtl/regfile_wb_queue.sv | 161 ++++++++++++++++
 tb/tb_regfile_wb_queue.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the register file write-back path: register
// select and data widths, the hardwired-zero register, and the layout
// of one write-back queue entry.
package mips_pkg;

    localparam int REG_AW = 5;
    localparam int DW     = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    // One queued result waiting to be written into the register file.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic [DW-1:0]     data;
    } wbq_entry_t;

endpackage

// File: rtl/wbq_fwd_lookup.sv
// Youngest-match search over the write-back queue. Walks the occupied
// entries from head (oldest) towards tail (youngest) so that a later match
// overrides an earlier one. Register 0 never hits.
module wbq_fwd_lookup
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wbq_entry_t                 i_entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   i_head,
    input  logic [$clog2(DEPTH):0]     i_count,
    input  logic [REG_AW-1:0]          i_sel,
    output logic                       o_hit,
    output logic [DW-1:0]              o_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] w_idx;

    // Scan oldest to youngest; the last matching entry wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PW'(k);
            if ((CW'(k) < i_count) &&
                i_entries[w_idx].valid &&
                (i_entries[w_idx].dst == i_sel) &&
                (i_sel != REG_ZERO)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-side initiator for the 32x32 register file. Collects results from
// the ALU (source A) and memory (source B), keeps them in an in-order
// queue and drains at most one per cycle into the register file write
// port. A is always older than B when both arrive together. Results aimed
// at register 0 are accepted and dropped.
//
// Build option: define WBQ_FWD_EN to enable the two forwarding lookup
// ports. Without it the fwd_hit/fwd_data outputs are tied to 0 and the
// pipeline is expected to interlock on count != 0 instead.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = mips_pkg::REG_AW,
    parameter int DW    = mips_pkg::DW
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [AW-1:0]            a_dst,
    input  logic [DW-1:0]            a_data,

    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [AW-1:0]            b_dst,
    input  logic [DW-1:0]            b_data,

    input  logic                     hold,

    output logic                     wr_en,
    output logic [AW-1:0]            wr_sel,
    output logic [DW-1:0]            wr_data,

    input  logic [AW-1:0]            fwd_sel0,
    output logic                     fwd_hit0,
    output logic [DW-1:0]            fwd_data0,

    input  logic [AW-1:0]            fwd_sel1,
    output logic                     fwd_hit1,
    output logic [DW-1:0]            fwd_data1,

    output logic [$clog2(DEPTH):0]   count
);

    import mips_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;
    wbq_entry_t     r_entries [DEPTH];

    logic [CW-1:0]  w_free;
    logic           w_aFire;
    logic           w_bFire;
    logic           w_aEnq;
    logic           w_bEnq;
    logic [1:0]     w_enqN;
    logic           w_deq;
    logic [PW-1:0]  w_bSlot;
    wbq_entry_t     w_headEntry;

    // Readiness looks only at the registered occupancy, so space freed by
    // this cycle's drain is not offered until the next cycle.
    assign w_free  = CW'(DEPTH) - r_count;
    assign a_ready = !rst && (w_free >= CW'(1));
    assign b_ready = !rst && ((w_free >= CW'(2)) ||
                              ((w_free == CW'(1)) && !a_valid));

    assign w_aFire = a_valid && a_ready;
    assign w_bFire = b_valid && b_ready;

    // Writes to register 0 complete the handshake but take no slot.
    assign w_aEnq  = w_aFire && (a_dst != REG_ZERO);
    assign w_bEnq  = w_bFire && (b_dst != REG_ZERO);
    assign w_enqN  = {1'b0, w_aEnq} + {1'b0, w_bEnq};

    // B lands right behind A when both are enqueued in the same cycle.
    assign w_bSlot = r_tail + PW'(w_aEnq);

    // The head is presented to the register file and popped on the same
    // edge that the register file captures it.
    assign w_deq       = (r_count != '0) && !hold && !rst;
    assign w_headEntry = r_entries[r_head];

    assign wr_en   = w_deq;
    assign wr_sel  = (r_count != '0) ? w_headEntry.dst  : '0;
    assign wr_data = (r_count != '0) ? w_headEntry.data : '0;
    assign count   = r_count;

    // Queue state: pointers, occupancy and entry storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_deq) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + PW'(1);
            end
            if (w_aEnq) begin
                r_entries[r_tail] <= '{valid: 1'b1, dst: a_dst, data: a_data};
            end
            if (w_bEnq) begin
                r_entries[w_bSlot] <= '{valid: 1'b1, dst: b_dst, data: b_data};
            end
            r_tail  <= r_tail + PW'(w_enqN);
            r_count <= r_count + CW'(w_enqN) - CW'(w_deq);
        end
    end

`ifdef WBQ_FWD_EN

    wbq_fwd_lookup #(
        .DEPTH (DEPTH)
    ) u_fwd0 (
        .i_entries (r_entries),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_sel     (fwd_sel0),
        .o_hit     (fwd_hit0),
        .o_data    (fwd_data0)
    );

    wbq_fwd_lookup #(
        .DEPTH (DEPTH)
    ) u_fwd1 (
        .i_entries (r_entries),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_sel     (fwd_sel1),
        .o_hit     (fwd_hit1),
        .o_data    (fwd_data1)
    );

`else

    logic w_unused_fwd;

    assign fwd_hit0  = 1'b0;
    assign fwd_data0 = '0;
    assign fwd_hit1  = 1'b0;
    assign fwd_data1 = '0;

    // Lookup selects and valid bits have no consumer in this build.
    always_comb begin
        w_unused_fwd = ^{fwd_sel0, fwd_sel1};
        for (int i = 0; i < DEPTH; i++) begin
            w_unused_fwd = w_unused_fwd ^ r_entries[i].valid;
        end
    end

`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for the register file write-back queue. Each task drives
// one scenario and compares outputs against hand-computed values.
// Forwarding expectations follow WBQ_FWD_EN: with it undefined every
// lookup must read back hit=0, data=0.
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

`ifdef WBQ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_dst;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_dst;
    logic [DW-1:0] b_data;
    logic          hold;
    logic          wr_en;
    logic [AW-1:0] wr_sel;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] fwd_sel0;
    logic          fwd_hit0;
    logic [DW-1:0] fwd_data0;
    logic [AW-1:0] fwd_sel1;
    logic          fwd_hit1;
    logic [DW-1:0] fwd_data1;
    logic [2:0]    count;

    int nChecks = 0;
    int nPassed = 0;

    regfile_wb_queue #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_dst     (a_dst),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_dst     (b_dst),
        .b_data    (b_data),
        .hold      (hold),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .fwd_sel0  (fwd_sel0),
        .fwd_hit0  (fwd_hit0),
        .fwd_data0 (fwd_data0),
        .fwd_sel1  (fwd_sel1),
        .fwd_hit1  (fwd_hit1),
        .fwd_data1 (fwd_data1),
        .count     (count)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change 1 unit after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idleSources;
        a_valid = 1'b0;
        a_dst   = '0;
        a_data  = '0;
        b_valid = 1'b0;
        b_dst   = '0;
        b_data  = '0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        hold     = 1'b0;
        fwd_sel0 = '0;
        fwd_sel1 = '0;
        idleSources();
        tick();
        tick();
        nChecks++;
        if ({a_ready, b_ready, wr_en} !== 3'b000)
            $display("[TB] FAIL reset_outputs: got %b expected 000", {a_ready, b_ready, wr_en});
        else nPassed++;
        nChecks++;
        if (count !== 3'd0)
            $display("[TB] FAIL reset_count: got %0d expected 0", count);
        else nPassed++;
        rst = 1'b0;
        #1;
        nChecks++;
        if ({a_ready, b_ready, wr_en} !== 3'b110)
            $display("[TB] FAIL post_reset_ready: got %b expected 110", {a_ready, b_ready, wr_en});
        else nPassed++;
        nChecks++;
        if ({wr_sel, wr_data, fwd_hit0, fwd_hit1} !== '0)
            $display("[TB] FAIL post_reset_idle: got sel=%0d data=%h hits=%b%b expected zeros",
                     wr_sel, wr_data, fwd_hit0, fwd_hit1);
        else nPassed++;
    endtask

    task automatic test_single_write;
        a_valid  = 1'b1;
        a_dst    = 5'd3;
        a_data   = 32'hafafafaf;
        fwd_sel0 = 5'd3;
        #1;
        nChecks++;
        if ({a_ready, fwd_hit0} !== 2'b10)
            $display("[TB] FAIL single_accept: got ready=%b hit=%b expected ready=1 hit=0", a_ready, fwd_hit0);
        else nPassed++;
        tick();
        idleSources();
        #1;
        nChecks++;
        if ({wr_en, wr_sel, wr_data} !== {1'b1, 5'd3, 32'hafafafaf})
            $display("[TB] FAIL single_write: got en=%b sel=%0d data=%h expected en=1 sel=3 data=afafafaf",
                     wr_en, wr_sel, wr_data);
        else nPassed++;
        nChecks++;
        if (count !== 3'd1)
            $display("[TB] FAIL single_count1: got %0d expected 1", count);
        else nPassed++;
        nChecks++;
        if ({fwd_hit0, fwd_data0} !== {FWD, FWD ? 32'hafafafaf : 32'h0})
            $display("[TB] FAIL single_fwd_head: got hit=%b data=%h expected hit=%b", fwd_hit0, fwd_data0, FWD);
        else nPassed++;
        tick();
        nChecks++;
        if ({wr_en, count} !== 4'b0000)
            $display("[TB] FAIL single_drained: got en=%b count=%0d expected en=0 count=0", wr_en, count);
        else nPassed++;
    endtask

    task automatic test_dual_order;
        hold     = 1'b1;
        a_valid  = 1'b1;
        a_dst    = 5'd5;
        a_data   = 32'h01010101;
        b_valid  = 1'b1;
        b_dst    = 5'd5;
        b_data   = 32'h02020202;
        fwd_sel0 = 5'd5;
        fwd_sel1 = 5'd5;
        #1;
        nChecks++;
        if ({a_ready, b_ready} !== 2'b11)
            $display("[TB] FAIL dual_ready: got %b expected 11", {a_ready, b_ready});
        else nPassed++;
        tick();
        idleSources();
        #1;
        nChecks++;
        if ({wr_en, count} !== {1'b0, 3'd2})
            $display("[TB] FAIL dual_held: got en=%b count=%0d expected en=0 count=2", wr_en, count);
        else nPassed++;
        nChecks++;
        if ({fwd_hit0, fwd_data0, fwd_hit1, fwd_data1} !==
            {FWD, FWD ? 32'h02020202 : 32'h0, FWD, FWD ? 32'h02020202 : 32'h0})
            $display("[TB] FAIL dual_fwd_youngest: got hit0=%b d0=%h hit1=%b d1=%h expected hit=%b",
                     fwd_hit0, fwd_data0, fwd_hit1, fwd_data1, FWD);
        else nPassed++;
        hold = 1'b0;
        #1;
        nChecks++;
        if ({wr_en, wr_sel, wr_data} !== {1'b1, 5'd5, 32'h01010101})
            $display("[TB] FAIL dual_first: got en=%b sel=%0d data=%h expected 1/5/01010101", wr_en, wr_sel, wr_data);
        else nPassed++;
        tick();
        nChecks++;
        if ({wr_en, wr_sel, wr_data, count} !== {1'b1, 5'd5, 32'h02020202, 3'd1})
            $display("[TB] FAIL dual_second: got en=%b sel=%0d data=%h count=%0d expected 1/5/02020202/1",
                     wr_en, wr_sel, wr_data, count);
        else nPassed++;
        tick();
        nChecks++;
        if ({wr_en, count, fwd_hit0} !== 5'b00000)
            $display("[TB] FAIL dual_drained: got en=%b count=%0d hit=%b expected zeros", wr_en, count, fwd_hit0);
        else nPassed++;
        fwd_sel0 = '0;
        fwd_sel1 = '0;
    endtask

    task automatic test_full_backpressure;
        int          expSel   [5] = '{1, 2, 3, 4, 9};
        logic [31:0] expData  [5] = '{32'h10000001, 32'h10000002, 32'h10000003,
                                      32'h10000004, 32'h99999999};
        int          expCount [5] = '{4, 3, 3, 2, 1};
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a_valid = 1'b1;
            a_dst   = 5'(i);
            a_data  = 32'h10000000 + 32'(i);
            #1;
            nChecks++;
            if (a_ready !== 1'b1)
                $display("[TB] FAIL full_fill_ready%0d: got %b expected 1", i, a_ready);
            else nPassed++;
            tick();
        end
        a_valid = 1'b1;
        a_dst   = 5'd9;
        a_data  = 32'h99999999;
        b_valid = 1'b1;
        b_dst   = 5'd10;
        b_data  = 32'h0a0a0a0a;
        #1;
        nChecks++;
        if ({count, a_ready, b_ready, wr_en} !== {3'd4, 3'b000})
            $display("[TB] FAIL full_stall: got count=%0d ra=%b rb=%b en=%b expected 4/0/0/0",
                     count, a_ready, b_ready, wr_en);
        else nPassed++;
        tick();
        tick();
        nChecks++;
        if ({count, wr_en} !== {3'd4, 1'b0})
            $display("[TB] FAIL full_hold_stable: got count=%0d en=%b expected 4/0", count, wr_en);
        else nPassed++;
        b_valid = 1'b0;
        hold    = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            nChecks++;
            if ({wr_en, wr_sel, wr_data, count} !== {1'b1, 5'(expSel[j]), expData[j], 3'(expCount[j])})
                $display("[TB] FAIL full_drain%0d: got en=%b sel=%0d data=%h count=%0d expected 1/%0d/%h/%0d",
                         j, wr_en, wr_sel, wr_data, count, expSel[j], expData[j], expCount[j]);
            else nPassed++;
            if (j == 0) begin
                nChecks++;
                if (a_ready !== 1'b0)
                    $display("[TB] FAIL full_no_credit: got %b expected 0", a_ready);
                else nPassed++;
            end
            if (j == 1) begin
                nChecks++;
                if ({a_ready, b_ready} !== 2'b10)
                    $display("[TB] FAIL full_reassert: got %b expected 10", {a_ready, b_ready});
                else nPassed++;
            end
            tick();
            if (j == 1) idleSources();
        end
        #1;
        nChecks++;
        if ({wr_en, count, a_ready, b_ready} !== {1'b0, 3'd0, 2'b11})
            $display("[TB] FAIL full_empty: got en=%b count=%0d ready=%b%b expected 0/0/11",
                     wr_en, count, a_ready, b_ready);
        else nPassed++;
    endtask

    task automatic test_b_only_free1;
        int          expSel  [4] = '{6, 7, 8, 11};
        logic [31:0] expData [4] = '{32'h66666666, 32'h77777777, 32'h88888888, 32'hbbbbbbbb};
        hold    = 1'b1;
        a_valid = 1'b1;
        a_dst   = 5'd6;
        a_data  = 32'h66666666;
        b_valid = 1'b1;
        b_dst   = 5'd7;
        b_data  = 32'h77777777;
        tick();
        a_dst   = 5'd8;
        a_data  = 32'h88888888;
        b_valid = 1'b0;
        tick();
        a_valid  = 1'b0;
        b_valid  = 1'b1;
        b_dst    = 5'd10;
        b_data   = 32'haaaaaaaa;
        fwd_sel0 = 5'd11;
        fwd_sel1 = 5'd10;
        #1;
        nChecks++;
        if ({count, a_ready, b_ready} !== {3'd3, 2'b11})
            $display("[TB] FAIL free1_b_only: got count=%0d ready=%b%b expected 3/11", count, a_ready, b_ready);
        else nPassed++;
        a_valid = 1'b1;
        a_dst   = 5'd11;
        a_data  = 32'hbbbbbbbb;
        #1;
        nChecks++;
        if ({a_ready, b_ready} !== 2'b10)
            $display("[TB] FAIL free1_a_priority: got %b expected 10", {a_ready, b_ready});
        else nPassed++;
        tick();
        idleSources();
        #1;
        nChecks++;
        if (count !== 3'd4)
            $display("[TB] FAIL free1_count: got %0d expected 4", count);
        else nPassed++;
        nChecks++;
        if ({fwd_hit0, fwd_data0, fwd_hit1, fwd_data1} !== {FWD, FWD ? 32'hbbbbbbbb : 32'h0, 1'b0, 32'h0})
            $display("[TB] FAIL free1_fwd: got hit0=%b d0=%h hit1=%b d1=%h", fwd_hit0, fwd_data0, fwd_hit1, fwd_data1);
        else nPassed++;
        hold = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            nChecks++;
            if ({wr_en, wr_sel, wr_data} !== {1'b1, 5'(expSel[j]), expData[j]})
                $display("[TB] FAIL free1_drain%0d: got en=%b sel=%0d data=%h expected 1/%0d/%h",
                         j, wr_en, wr_sel, wr_data, expSel[j], expData[j]);
            else nPassed++;
            tick();
        end
        #1;
        nChecks++;
        if ({wr_en, count} !== 4'b0000)
            $display("[TB] FAIL free1_empty: got en=%b count=%0d expected 0/0", wr_en, count);
        else nPassed++;
        fwd_sel0 = '0;
        fwd_sel1 = '0;
    endtask

    task automatic test_reg_zero;
        a_valid  = 1'b1;
        a_dst    = 5'd0;
        a_data   = 32'hffffffff;
        fwd_sel0 = 5'd0;
        #1;
        nChecks++;
        if ({a_ready, fwd_hit0, fwd_data0} !== {2'b10, 32'h0})
            $display("[TB] FAIL zero_accept: got ready=%b hit=%b data=%h expected 1/0/0", a_ready, fwd_hit0, fwd_data0);
        else nPassed++;
        tick();
        idleSources();
        #1;
        nChecks++;
        if ({wr_en, count} !== 4'b0000)
            $display("[TB] FAIL zero_dropped: got en=%b count=%0d expected 0/0", wr_en, count);
        else nPassed++;
        a_valid = 1'b1;
        a_dst   = 5'd12;
        a_data  = 32'hcccccccc;
        b_valid = 1'b1;
        b_dst   = 5'd0;
        b_data  = 32'hdddddddd;
        #1;
        nChecks++;
        if ({a_ready, b_ready} !== 2'b11)
            $display("[TB] FAIL zero_mixed_ready: got %b expected 11", {a_ready, b_ready});
        else nPassed++;
        tick();
        idleSources();
        #1;
        nChecks++;
        if ({count, wr_en, wr_sel, wr_data} !== {3'd1, 1'b1, 5'd12, 32'hcccccccc})
            $display("[TB] FAIL zero_mixed_write: got count=%0d en=%b sel=%0d data=%h expected 1/1/12/cccccccc",
                     count, wr_en, wr_sel, wr_data);
        else nPassed++;
        tick();
        nChecks++;
        if ({wr_en, count} !== 4'b0000)
            $display("[TB] FAIL zero_mixed_empty: got en=%b count=%0d expected 0/0", wr_en, count);
        else nPassed++;
    endtask

    task automatic test_reset_mid;
        hold    = 1'b1;
        a_valid = 1'b1;
        a_dst   = 5'd13;
        a_data  = 32'h13131313;
        b_valid = 1'b1;
        b_dst   = 5'd14;
        b_data  = 32'h14141414;
        tick();
        a_dst   = 5'd15;
        a_data  = 32'h15151515;
        b_valid = 1'b0;
        tick();
        idleSources();
        fwd_sel0 = 5'd13;
        fwd_sel1 = 5'd15;
        #1;
        nChecks++;
        if ({count, fwd_hit0, fwd_hit1} !== {3'd3, FWD, FWD})
            $display("[TB] FAIL mid_queued: got count=%0d hits=%b%b expected 3/%b%b", count, fwd_hit0, fwd_hit1, FWD, FWD);
        else nPassed++;
        rst  = 1'b1;
        hold = 1'b0;
        #1;
        nChecks++;
        if ({wr_en, a_ready, b_ready} !== 3'b000)
            $display("[TB] FAIL mid_reset_cycle: got en=%b ready=%b%b expected 000", wr_en, a_ready, b_ready);
        else nPassed++;
        tick();
        rst = 1'b0;
        #1;
        nChecks++;
        if ({count, wr_en, fwd_hit0, fwd_hit1} !== 6'b000000)
            $display("[TB] FAIL mid_cleared: got count=%0d en=%b hits=%b%b expected zeros", count, wr_en, fwd_hit0, fwd_hit1);
        else nPassed++;
        nChecks++;
        if ({wr_sel, wr_data} !== '0)
            $display("[TB] FAIL mid_head_zero: got sel=%0d data=%h expected 0/0", wr_sel, wr_data);
        else nPassed++;
        tick();
        nChecks++;
        if ({wr_en, count} !== 4'b0000)
            $display("[TB] FAIL mid_no_writes: got en=%b count=%0d expected 0/0", wr_en, count);
        else nPassed++;
    endtask

    // Scenario sequence, then the pass summary.
    initial begin
        test_reset();
        test_single_write();
        test_dual_order();
        test_full_backpressure();
        test_b_only_free1();
        test_reg_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
